// File: rtl/win7_frame_sequencer_if.sv
// Handshake/status bundle between the pixel source and the 7x7 frame sequencer.
// err_o exists only when WIN7_SEQ_ERR_EN is defined.
interface win7_frame_sequencer_if #(
    parameter int unsigned CW = 3
);
    logic          start_i;
    logic          valid_i;
    logic          ready_o;
    logic          shift_o;
    logic          o_en;
    logic [CW-1:0] cx_o;
    logic [CW-1:0] cy_o;
    logic          busy_o;
    logic          done_o;
`ifdef WIN7_SEQ_ERR_EN
    logic          err_o;

    modport master (
        output start_i, valid_i,
        input  ready_o, shift_o, o_en, cx_o, cy_o, busy_o, done_o, err_o
    );
    modport slave (
        input  start_i, valid_i,
        output ready_o, shift_o, o_en, cx_o, cy_o, busy_o, done_o, err_o
    );
`else
    modport master (
        output start_i, valid_i,
        input  ready_o, shift_o, o_en, cx_o, cy_o, busy_o, done_o
    );
    modport slave (
        input  start_i, valid_i,
        output ready_o, shift_o, o_en, cx_o, cy_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/win7_frame_sequencer.sv
// Raster-position sequencer for the 7x7 window datapath: shift enable, window-valid, centre coords, done.
// Optional sticky protocol-error flag err_o enabled by WIN7_SEQ_ERR_EN.
module win7_frame_sequencer #(
    parameter int unsigned ROWS = 7,
    parameter int unsigned COLS = 7,
    parameter int unsigned K    = 7,
    parameter int unsigned CW   = $clog2((ROWS > COLS) ? ROWS : COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    win7_frame_sequencer_if.slave  bus
);

    if (K != 7) begin : g_k_check
        $error("win7_frame_sequencer: K must be 7");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          ready_q;
    logic          busy_q;
    logic          o_en_q;
    logic          done_q;
    logic [CW-1:0] cx_q;
    logic [CW-1:0] cy_q;

    logic          accept_c;
    logic          last_col_c;
    logic          last_pix_c;
    logic          win_hit_c;

    assign accept_c   = bus.valid_i && ready_q;
    assign last_col_c = (col == CW'(COLS - 1));
    assign last_pix_c = accept_c && last_col_c && (row == CW'(ROWS - 1));
    // Window is complete once the accepted pixel sits at or beyond the bottom-right of a 7x7 block.
    assign win_hit_c  = accept_c && (row >= CW'(K - 1)) && (col >= CW'(K - 1));

    assign bus.ready_o = ready_q;
    assign bus.shift_o = accept_c;
    assign bus.busy_o  = busy_q;
    assign bus.o_en    = o_en_q;
    assign bus.done_o  = done_q;
    assign bus.cx_o    = cx_q;
    assign bus.cy_o    = cy_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start_i) state_nxt = S_ARMED;
            S_ARMED: if (accept_c)    state_nxt = last_pix_c ? S_FLUSH : S_RUN;
            S_RUN:   if (last_pix_c)  state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (state == S_FLUSH) begin
            row <= '0;
            col <= '0;
        end else if (accept_c) begin
            if (last_col_c) begin
                col <= '0;
                row <= (row == CW'(ROWS - 1)) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // ready/busy track the upcoming state so they are flops rather than state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            o_en_q  <= 1'b0;
            done_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            ready_q <= (state_nxt == S_ARMED) || (state_nxt == S_RUN);
            busy_q  <= (state_nxt != S_IDLE);
            o_en_q  <= win_hit_c;
            done_q  <= last_pix_c;
            if (win_hit_c) begin
                cx_q <= col - CW'(3);
                cy_q <= row - CW'(3);
            end
        end
    end

`ifdef WIN7_SEQ_ERR_EN
    logic err_q;
    logic err_set_c;

    assign err_set_c = (bus.valid_i && ((state == S_IDLE) || (state == S_FLUSH)))
                    || (bus.start_i && (state != S_IDLE));

    // Sticky: a new violation wins over the clearing start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set_c) begin
            err_q <= 1'b1;
        end else if (bus.start_i && (state == S_IDLE)) begin
            err_q <= 1'b0;
        end
    end

    assign bus.err_o = err_q;
`endif

endmodule
